prbs_bit_gen: RTL and testbench

- Serial test-pattern source feeding the TX bit path. It drives data_in / data_in_valid of the Gray-code PAM4 symbol encoder directly.
- Generates PRBS7, PRBS15 or PRBS31 from a loadable LFSR, or a 1010 clock pattern, one bit per enabled cycle.
- Supports single-bit error injection so the RX-side checker and BER counters can be validated.

---
 rtl/prbs_bit_gen.sv | 167 ++++++++++++++++
 tb/tb_prbs_bit_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_bit_gen.sv
// prbs_bit_gen
// ------------
// Serial test-pattern source for the TX bit path. It produces PRBS7, PRBS15
// or PRBS31 from a loadable Fibonacci LFSR, or a 1010 clock pattern. One bit
// is emitted per enabled cycle. A single-bit error can be injected so that
// the RX-side checker and BER counters can be exercised.
//
// Ports
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   en             advance the generator and emit one valid bit this cycle
//   mode[1:0]      00 PRBS7, 01 PRBS15, 10 PRBS31, 11 alternating 1010;
//                  sampled only when seed_load is high
//   seed_load      load seed and mode, clear counters (wins over en)
//   seed[30:0]     LFSR seed; only the low N bits of the new mode matter
//   err_inject     request inversion of the next emitted bit
//   data_out       pattern bit (registered)
//   data_out_valid data_out is valid this cycle
//   bit_count      valid bits since reset or last seed_load; wraps
//   err_count      injected errors emitted; saturates at all-ones
module prbs_bit_gen #(
  parameter logic [30:0] SEED_DEFAULT = 31'h7FFF_FFFF,
  parameter int unsigned ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic                 seed_load,
  input  logic [30:0]          seed,
  input  logic                 err_inject,
  output logic                 data_out,
  output logic                 data_out_valid,
  output logic [31:0]          bit_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0] MODE_PRBS7  = 2'b00;
  localparam logic [1:0] MODE_PRBS15 = 2'b01;
  localparam logic [1:0] MODE_PRBS31 = 2'b10;
  localparam logic [1:0] MODE_ALT    = 2'b11;

  // Mask of the LFSR bits that take part in a given mode. The alternating
  // mode uses no LFSR bits, so its mask is empty. That empty mask freezes
  // the register and also disables lock-up avoidance on load.
  function automatic logic [30:0] len_mask(input logic [1:0] m);
    logic [30:0] r;
    case (m)
      MODE_PRBS7:  r = 31'h0000_007F;
      MODE_PRBS15: r = 31'h0000_7FFF;
      MODE_PRBS31: r = 31'h7FFF_FFFF;
      default:     r = 31'h0000_0000;
    endcase
    return r;
  endfunction

  // State
  logic [1:0]           mode_reg;
  logic [30:0]          lfsr_reg;
  logic                 alt_reg;
  logic                 pend_reg;
  logic                 data_out_reg;
  logic                 valid_reg;
  logic [31:0]          bit_count_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;

  // Combinational helpers
  logic [30:0] active_mask;
  logic [30:0] load_mask;
  logic [30:0] lfsr_step;
  logic [30:0] lfsr_load;
  logic        fb;
  logic        pattern_bit;
  logic        inj;
  logic        seed_zero;
  logic        err_sat;

  assign active_mask = len_mask(mode_reg);
  assign load_mask   = len_mask(mode);

  // Feedback taps of the currently active polynomial.
  always_comb begin
    fb = 1'b0;
    case (mode_reg)
      MODE_PRBS7:  fb = lfsr_reg[6]  ^ lfsr_reg[5];
      MODE_PRBS15: fb = lfsr_reg[14] ^ lfsr_reg[13];
      MODE_PRBS31: fb = lfsr_reg[30] ^ lfsr_reg[27];
      default:     fb = 1'b0;
    endcase
  end

  // Per-bit next state for a step. Bits inside the active length shift up
  // by one position, and bit 0 takes the feedback. Bits above the active
  // length hold their value, so a later mode switch still sees the
  // untouched upper seed bits.
  genvar gi;
  generate
    for (gi = 0; gi < 31; gi++) begin : g_lfsr_bit
      if (gi == 0) begin : g_lsb
        assign lfsr_step[gi] = active_mask[gi] ? fb : lfsr_reg[gi];
      end else begin : g_upper
        assign lfsr_step[gi] = active_mask[gi] ? lfsr_reg[gi-1] : lfsr_reg[gi];
      end
    end
  endgenerate

  // An all-zero seed would lock the LFSR at zero forever. In that case the
  // active bits are forced to ones, and the upper bits still come from the
  // seed.
  assign seed_zero = ((seed & load_mask) == 31'd0) && (mode != MODE_ALT);
  assign lfsr_load = seed_zero ? (seed | load_mask) : seed;

  assign pattern_bit = (mode_reg == MODE_ALT) ? alt_reg : fb;

  // A pending request from an idle cycle combines with a live request. Both
  // therefore collapse into a single inversion on the next step.
  assign inj     = err_inject | pend_reg;
  assign err_sat = &err_count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_reg      <= MODE_PRBS7;
      lfsr_reg      <= SEED_DEFAULT;
      alt_reg       <= 1'b1;
      pend_reg      <= 1'b0;
      data_out_reg  <= 1'b0;
      valid_reg     <= 1'b0;
      bit_count_reg <= 32'd0;
      err_count_reg <= '0;
    end else if (seed_load) begin
      // A load takes precedence over en. An error request arriving on the
      // same cycle is dropped together with the cleared pending flag.
      mode_reg      <= mode;
      lfsr_reg      <= lfsr_load;
      alt_reg       <= 1'b1;
      pend_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      bit_count_reg <= 32'd0;
      err_count_reg <= '0;
    end else if (en) begin
      lfsr_reg      <= lfsr_step;
      if (mode_reg == MODE_ALT) begin
        alt_reg <= ~alt_reg;
      end
      data_out_reg  <= pattern_bit ^ inj;
      valid_reg     <= 1'b1;
      bit_count_reg <= bit_count_reg + 32'd1;
      pend_reg      <= 1'b0;
      if (inj && !err_sat) begin
        err_count_reg <= err_count_reg + ERR_CNT_W'(1);
      end
    end else begin
      // Idle cycle: data_out keeps its last value. Any error request is
      // remembered until the next step.
      valid_reg <= 1'b0;
      if (err_inject) begin
        pend_reg <= 1'b1;
      end
    end
  end

  assign data_out       = data_out_reg;
  assign data_out_valid = valid_reg;
  assign bit_count      = bit_count_reg;
  assign err_count      = err_count_reg;

endmodule

// File: tb/tb_prbs_bit_gen.sv
module tb_prbs_bit_gen;

  localparam int          ERR_W   = 4;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;
  localparam logic [30:0] SEED_D  = 31'h7FFF_FFFF;

  logic             clk;
  logic             rstn;
  logic             en;
  logic [1:0]       mode;
  logic             seed_load;
  logic [30:0]      seed;
  logic             err_inject;
  logic             data_out;
  logic             data_out_valid;
  logic [31:0]      bit_count;
  logic [ERR_W-1:0] err_count;

  prbs_bit_gen #(
    .SEED_DEFAULT (SEED_D),
    .ERR_CNT_W    (ERR_W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .mode           (mode),
    .seed_load      (seed_load),
    .seed           (seed),
    .err_inject     (err_inject),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .bit_count      (bit_count),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The PRBS is modelled as a linear recurrence on the emitted bit history.
  // The history holds the last N bits, oldest first. It starts as the seed
  // bits s[N-1]..s[0]. The next bit is hist[0] ^ hist[d], where d is the
  // tap distance.
  bit   m_hist[$];
  int   m_mode;
  bit   m_alt, m_pend, m_valid, m_dout;
  int   m_errs;
  logic [31:0] m_bits;
  logic cap[$];

  function automatic int plen(input int md);
    return (md == 0) ? 7 : (md == 1) ? 15 : 31;
  endfunction

  function automatic int ptap(input int md);
    return (md == 2) ? 3 : 1;
  endfunction

  task automatic m_load(input int md, input logic [30:0] sd);
    int n;
    bit allz;
    m_hist.delete();
    if (md == 3) return;
    n = plen(md);
    allz = 1'b1;
    for (int k = n - 1; k >= 0; k--) begin
      m_hist.push_back(sd[k]);
      if (sd[k]) allz = 1'b0;
    end
    if (allz) foreach (m_hist[k]) m_hist[k] = 1'b1;
  endtask

  function automatic bit m_next_prbs();
    bit b;
    b = m_hist[0] ^ m_hist[ptap(m_mode)];
    m_hist.push_back(b);
    void'(m_hist.pop_front());
    return b;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_load(0, SEED_D);
    m_alt = 1; m_pend = 0; m_valid = 0; m_dout = 0; m_errs = 0; m_bits = 0;
  endtask

  task automatic model_clock(input logic e, input logic sl, input logic [1:0] md,
                             input logic [30:0] sd, input logic inj);
    bit b, i;
    if (sl) begin
      m_mode = int'(md);
      m_load(m_mode, sd);
      m_alt = 1; m_pend = 0; m_bits = 0; m_errs = 0; m_valid = 0;
    end else if (e) begin
      if (m_mode == 3) begin
        b = m_alt;
        m_alt = !m_alt;
      end else begin
        b = m_next_prbs();
      end
      i = inj | m_pend;
      m_pend = 0;
      m_dout = b ^ i;
      m_valid = 1;
      m_bits = m_bits + 32'd1;
      if (i && m_errs < ERR_MAX) m_errs++;
    end else begin
      m_valid = 0;
      if (inj) m_pend = 1;
    end
  endtask

  // One clock of stimulus, model update and output check.
  task automatic drive(input logic e, input logic sl, input logic [1:0] md,
                       input logic [30:0] sd, input logic inj);
    @(negedge clk);
    en = e; seed_load = sl; mode = md; seed = sd; err_inject = inj;
    @(posedge clk);
    model_clock(e, sl, md, sd, inj);
    #1;
    check("valid", {31'd0, data_out_valid}, {31'd0, m_valid});
    check("data", {31'd0, data_out}, {31'd0, m_dout});
    check("bit_count", bit_count, m_bits);
    check("err_count", {{(32-ERR_W){1'b0}}, err_count}, 32'(m_errs));
    if (data_out_valid) cap.push_back(data_out);
  endtask

  task automatic rand_run(input int cycles, input bit allow_load);
    logic e, sl, inj;
    logic [1:0] md;
    logic [30:0] sd;
    for (int c = 0; c < cycles; c++) begin
      e   = ($urandom_range(0, 3) != 0);
      inj = ($urandom_range(0, 11) == 0);
      sl  = allow_load && ($urandom_range(0, 60) == 0);
      md  = 2'($urandom);
      sd  = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
      drive(e, sl, md, sd, inj);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp7[7] = '{0, 0, 0, 0, 0, 0, 1};
    int ones;

    rstn = 1'b0; en = 0; seed_load = 0; mode = 0; seed = 0; err_inject = 0;
    model_reset();
    #12;
    check("rst_data", {31'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check("rst_bits", bit_count, 32'd0);
    check("rst_errs", {{(32-ERR_W){1'b0}}, err_count}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    $display("reset: released");

    // PRBS7 from seed 7F: known first bits, period 127, 64 ones.
    drive(0, 1, 2'b00, 31'h7F, 0);
    cap.delete();
    for (int k = 0; k < 254; k++) drive(1, 0, 2'b00, 31'h0, 0);
    for (int k = 0; k < 7; k++) check($sformatf("prbs7_first%0d", k), {31'd0, cap[k]}, {31'd0, exp7[k]});
    ones = 0;
    for (int k = 0; k < 127; k++) begin
      if (cap[k]) ones++;
      check("prbs7_period", {31'd0, cap[k + 127]}, {31'd0, cap[k]});
    end
    check("prbs7_ones", 32'(ones), 32'd64);
    $display("prbs7: %0d bits, %0d ones in first period", cap.size(), ones);

    // PRBS15 with zero seed (lock-up avoidance), random en/err_inject.
    drive(0, 1, 2'b01, 31'h0, 0);
    rand_run(600, 0);
    $display("prbs15: random run done, bit_count=%0d", bit_count);

    // PRBS31 with a random seed.
    drive(0, 1, 2'b10, 31'($urandom), 0);
    rand_run(600, 0);
    $display("prbs31: random run done, bit_count=%0d", bit_count);

    // Alternating pattern with idle gap.
    drive(0, 1, 2'b11, 31'h0, 0);
    cap.delete();
    for (int k = 0; k < 6; k++) drive(1, 0, 2'b00, 31'h0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 2'b00, 31'h0, 0);
    for (int k = 0; k < 2; k++) drive(1, 0, 2'b00, 31'h0, 0);
    check("alt_len", 32'(cap.size()), 32'd8);
    for (int k = 0; k < cap.size(); k++) check($sformatf("alt_bit%0d", k), {31'd0, cap[k]}, 32'((k % 2) == 0));
    check("alt_bits", bit_count, 32'd8);
    $display("alternating: %0d bits captured", cap.size());

    // Error injection while idle, then steps.
    drive(0, 1, 2'b00, 31'($urandom), 0);
    for (int k = 0; k < 5; k++) drive(1, 0, 2'b00, 31'h0, 0);
    drive(0, 0, 2'b00, 31'h0, 1);
    for (int k = 0; k < 5; k++) drive(1, 0, 2'b00, 31'h0, 0);
    check("inj_single", {{(32-ERR_W){1'b0}}, err_count}, 32'd1);
    drive(0, 1, 2'b00, 31'h55, 0);
    drive(0, 0, 2'b00, 31'h0, 1);
    drive(0, 0, 2'b00, 31'h0, 1);
    drive(1, 0, 2'b00, 31'h0, 0);
    drive(1, 0, 2'b00, 31'h0, 0);
    check("inj_collapse", {{(32-ERR_W){1'b0}}, err_count}, 32'd1);
    $display("error inject: err_count=%0d", err_count);

    // seed_load with en and err_inject on the same cycle.
    drive(1, 1, 2'b00, 31'h7F, 1);
    check("load_en_valid", {31'd0, data_out_valid}, 32'd0);
    check("load_en_bits", bit_count, 32'd0);
    cap.delete();
    for (int k = 0; k < 7; k++) drive(1, 0, 2'b00, 31'h0, 0);
    for (int k = 0; k < 7; k++) check($sformatf("load_en_first%0d", k), {31'd0, cap[k]}, {31'd0, exp7[k]});
    check("load_inj_drop", {{(32-ERR_W){1'b0}}, err_count}, 32'd0);
    $display("load+en: restart checked");

    // Error counter saturation.
    drive(0, 1, 2'b01, 31'($urandom), 0);
    for (int k = 0; k < ERR_MAX + 5; k++) drive(1, 0, 2'b00, 31'h0, 1);
    check("err_sat", {{(32-ERR_W){1'b0}}, err_count}, 32'(ERR_MAX));
    $display("saturation: err_count=%0d", err_count);

    // Mixed random traffic with loads and ignored mode changes.
    rand_run(1500, 1);
    $display("random mixed: done, bit_count=%0d", bit_count);

    // Asynchronous reset mid-stream.
    drive(0, 1, 2'b10, 31'($urandom), 0);
    for (int k = 0; k < 10; k++) drive(1, 0, 2'b00, 31'h0, 0);
    en = 0; seed_load = 0; err_inject = 0;
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check("arst_data", {31'd0, data_out}, 32'd0);
    check("arst_valid", {31'd0, data_out_valid}, 32'd0);
    check("arst_bits", bit_count, 32'd0);
    check("arst_errs", {{(32-ERR_W){1'b0}}, err_count}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    cap.delete();
    for (int k = 0; k < 40; k++) drive(1, 0, 2'b10, 31'h0, 0);
    for (int k = 0; k < 7; k++) check($sformatf("arst_first%0d", k), {31'd0, cap[k]}, {31'd0, exp7[k]});
    $display("async reset: restart checked, bit_count=%0d", bit_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
